// File: rtl/issue_sequencer_if.sv
// Fetch, decoder, execute and writeback signals of the issue sequencer.
// The sequencer takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface issue_sequencer_if;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        dec_enable;
   logic [31:0] dec_instr;
   logic        ex_valid;
   logic        ex_ready;
   logic        wb_valid;
   logic [4:0]  wb_rd;

   modport master (
      output in_valid, in_instr, ex_ready, wb_valid, wb_rd,
      input  in_ready, dec_enable, dec_instr, ex_valid
   );

   modport slave (
      input  in_valid, in_instr, ex_ready, wb_valid, wb_rd,
      output in_ready, dec_enable, dec_instr, ex_valid
   );
endinterface

// File: rtl/issue_sequencer.sv
// Decode-stage sequencer: accept -> decode -> issue, with a 32-entry RAW/WAW scoreboard and EBREAK halt.
// Optional macro SB_WB_BYPASS_EN lets the hazard check see this cycle's writeback clear.
module issue_sequencer #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned CNT_W           = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   issue_sequencer_if.slave  bus,
   input  logic              resume,
   output logic              halted,
   output logic [CNT_W-1:0]  outstanding,
   output logic [31:0]       scoreboard
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      ISSUE  = 2'd2,
      HALT   = 2'd3
   } state_t;

   localparam logic [6:0]       OP_R      = 7'b0110011;
   localparam logic [6:0]       OP_IMM    = 7'b0010011;
   localparam logic [6:0]       OP_LOAD   = 7'b0000011;
   localparam logic [6:0]       OP_JALR   = 7'b1100111;
   localparam logic [6:0]       OP_STORE  = 7'b0100011;
   localparam logic [6:0]       OP_BRANCH = 7'b1100011;
   localparam logic [6:0]       OP_LUI    = 7'b0110111;
   localparam logic [6:0]       OP_AUIPC  = 7'b0010111;
   localparam logic [6:0]       OP_JAL    = 7'b1101111;
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

   function automatic logic is_r_type(input logic [31:0] i);
      return i[6:0] == OP_R;
   endfunction

   function automatic logic is_si_type(input logic [31:0] i);
      return (i[6:0] == OP_IMM) && ((i[14:12] == 3'b001) || (i[14:12] == 3'b101));
   endfunction

   function automatic logic is_i_type(input logic [31:0] i);
      return ((i[6:0] == OP_IMM) && !is_si_type(i)) || (i[6:0] == OP_LOAD) || (i[6:0] == OP_JALR);
   endfunction

   function automatic logic is_s_type(input logic [31:0] i);
      return i[6:0] == OP_STORE;
   endfunction

   function automatic logic is_b_type(input logic [31:0] i);
      return i[6:0] == OP_BRANCH;
   endfunction

   function automatic logic is_u_type(input logic [31:0] i);
      return (i[6:0] == OP_LUI) || (i[6:0] == OP_AUIPC);
   endfunction

   function automatic logic is_j_type(input logic [31:0] i);
      return i[6:0] == OP_JAL;
   endfunction

   function automatic logic uses_rs1(input logic [31:0] i);
      return is_r_type(i) || is_i_type(i) || is_si_type(i) || is_s_type(i) || is_b_type(i);
   endfunction

   function automatic logic uses_rs2(input logic [31:0] i);
      return is_r_type(i) || is_s_type(i) || is_b_type(i);
   endfunction

   function automatic logic writes_rd(input logic [31:0] i);
      return is_r_type(i) || is_i_type(i) || is_si_type(i) || is_u_type(i) || is_j_type(i);
   endfunction

   // EBREAK and every unrecognised encoding halt, so bad fetch data cannot run on.
   function automatic logic is_halt(input logic [31:0] i);
      return !(writes_rd(i) || is_s_type(i) || is_b_type(i));
   endfunction

   function automatic logic hazard(input logic [31:0] i, input logic [31:0] sb,
                                   input logic [CNT_W-1:0] cnt);
      logic rd_hit;
      rd_hit = writes_rd(i) && (i[11:7] != 5'd0) && (sb[i[11:7]] || (cnt >= MAX_CNT));
      return (uses_rs1(i) && sb[i[19:15]]) || (uses_rs2(i) && sb[i[24:20]]) || rd_hit;
   endfunction

   state_t            state_r, state_s;
   logic [31:0]       dec_instr_r, sb_r, sb_nxt_s, sb_chk_s, wb_clr_s, iss_set_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s, cnt_chk_s;
   logic              run_r, wb_hit_s, wb_dec_s, hs_s, iss_inc_s, in_ready_s, accept_s;
   logic              dec_enable_s, ex_valid_s, halted_s;

   // Writeback and issue effects on the scoreboard.
   always_comb begin
      wb_hit_s  = bus.wb_valid && (bus.wb_rd != 5'd0);
      wb_clr_s  = wb_hit_s ? (32'd1 << bus.wb_rd) : 32'd0;
      hs_s      = (state_r == ISSUE) && bus.ex_ready;
      iss_set_s = (hs_s && writes_rd(dec_instr_r) && (dec_instr_r[11:7] != 5'd0))
                  ? (32'd1 << dec_instr_r[11:7]) : 32'd0;
      iss_inc_s = |iss_set_s;
      // A clear on the register being set in the same cycle still counts, so the two cancel.
      wb_dec_s  = wb_hit_s && (sb_r[bus.wb_rd] || iss_set_s[bus.wb_rd]);
      sb_nxt_s  = ((sb_r & ~wb_clr_s) | iss_set_s) & ~32'd1;
   end

   // Hazard view used for acceptance.
   always_comb begin
`ifdef SB_WB_BYPASS_EN
      sb_chk_s  = sb_r & ~wb_clr_s;
      cnt_chk_s = (wb_hit_s && sb_r[bus.wb_rd] && (cnt_r != CNT_ZERO)) ? (cnt_r - CNT_ONE) : cnt_r;
`else
      sb_chk_s  = sb_r;
      cnt_chk_s = cnt_r;
`endif
      in_ready_s = run_r && (state_r == IDLE) && !hazard(bus.in_instr, sb_chk_s, cnt_chk_s);
      accept_s   = bus.in_valid && in_ready_s;
   end

   // Outstanding counter update, saturating at both ends.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (iss_inc_s && !wb_dec_s) begin
         if (cnt_r < MAX_CNT) cnt_nxt_s = cnt_r + CNT_ONE;
         else                 cnt_nxt_s = cnt_r;
      end else if (wb_dec_s && !iss_inc_s) begin
         if (cnt_r != CNT_ZERO) cnt_nxt_s = cnt_r - CNT_ONE;
         else                   cnt_nxt_s = cnt_r;
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_s;
   end

   // FSM next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE:    if (accept_s) state_s = DECODE; else state_s = IDLE;
         DECODE:  state_s = ISSUE;
         ISSUE: begin
            if (hs_s) state_s = is_halt(dec_instr_r) ? HALT : IDLE;
            else      state_s = ISSUE;
         end
         HALT:    if (resume) state_s = IDLE; else state_s = HALT;
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs, decoded from the state register only.
   always_comb begin
      dec_enable_s = 1'b0;
      ex_valid_s   = 1'b0;
      halted_s     = 1'b0;
      case (state_r)
         DECODE:  dec_enable_s = 1'b1;
         ISSUE:   ex_valid_s   = 1'b1;
         HALT:    halted_s     = 1'b1;
         default: dec_enable_s = 1'b0;
      endcase
   end

   // Datapath registers; run_r keeps in_ready low until the first edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_r       <= 1'b0;
         dec_instr_r <= 32'd0;
         sb_r        <= 32'd0;
         cnt_r       <= CNT_ZERO;
      end else begin
         run_r <= 1'b1;
         if (accept_s) dec_instr_r <= bus.in_instr;
         else          dec_instr_r <= dec_instr_r;
         sb_r  <= sb_nxt_s;
         cnt_r <= cnt_nxt_s;
      end
   end

   assign bus.in_ready   = in_ready_s;
   assign bus.dec_enable = dec_enable_s;
   assign bus.dec_instr  = dec_instr_r;
   assign bus.ex_valid   = ex_valid_s;
   assign halted         = halted_s;
   assign outstanding    = cnt_r;
   assign scoreboard     = sb_r;
endmodule

// File: tb/tb_issue_sequencer.sv
// Directed bench for issue_sequencer: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_issue_sequencer;
   localparam logic [31:0] ADD3  = 32'h002081B3;
   localparam logic [31:0] ADDI1 = 32'h00100093;
   localparam logic [31:0] ADDI2 = 32'h00100113;
   localparam logic [31:0] ADDI3 = 32'h00100193;
   localparam logic [31:0] ADDI4 = 32'h00100213;
   localparam logic [31:0] ADDI5 = 32'h00100293;
   localparam logic [31:0] ADDI7 = 32'h00100393;
   localparam logic [31:0] ADD6  = 32'h00528333;
   localparam logic [31:0] SW12  = 32'h00112023;
   localparam logic [31:0] EBRK  = 32'h00100073;
   localparam logic [31:0] ILL   = 32'hFFFFFFFF;
   localparam logic [31:0] Z     = 32'h00000000;

   logic        clk;
   logic        rst_n;
   logic        resume;
   logic        halted;
   logic [3:0]  outstanding;
   logic [31:0] scoreboard;
   int          checks = 0;
   int          errors = 0;

   issue_sequencer_if bus_if();

   issue_sequencer #(.MAX_OUTSTANDING(4), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus_if),
      .resume      (resume),
      .halted      (halted),
      .outstanding (outstanding),
      .scoreboard  (scoreboard)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] instr;
      logic        exr;
      logic        wbv;
      logic [4:0]  wbrd;
      logic        res;
      logic        rdy;
      logic        den;
      logic        exv;
      logic        hlt;
      logic [3:0]  out;
      logic [31:0] sb;
   } vec_t;

   function automatic vec_t mk(logic iv, logic [31:0] instr, logic exr, logic wbv, logic [4:0] wbrd,
                               logic res, logic rdy, logic den, logic exv, logic hlt,
                               logic [3:0] out, logic [31:0] sb);
      vec_t v;
      v.iv = iv; v.instr = instr; v.exr = exr; v.wbv = wbv; v.wbrd = wbrd; v.res = res;
      v.rdy = rdy; v.den = den; v.exv = exv; v.hlt = hlt; v.out = out; v.sb = sb;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One cycle: drive after the edge, compare mid-cycle.
   task automatic cyc(input string tag, input vec_t v);
      @(posedge clk);
      #1;
      bus_if.in_valid = v.iv;
      bus_if.in_instr = v.instr;
      bus_if.ex_ready = v.exr;
      bus_if.wb_valid = v.wbv;
      bus_if.wb_rd    = v.wbrd;
      resume          = v.res;
      #3;
      chk({tag, " in_ready"},    {31'd0, bus_if.in_ready},   {31'd0, v.rdy});
      chk({tag, " dec_enable"},  {31'd0, bus_if.dec_enable}, {31'd0, v.den});
      chk({tag, " ex_valid"},    {31'd0, bus_if.ex_valid},   {31'd0, v.exv});
      chk({tag, " halted"},      {31'd0, halted},            {31'd0, v.hlt});
      chk({tag, " outstanding"}, {28'd0, outstanding},       {28'd0, v.out});
      chk({tag, " scoreboard"},  scoreboard,                 v.sb);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, " rst in_ready"},    {31'd0, bus_if.in_ready},   32'd0);
      chk({tag, " rst dec_enable"},  {31'd0, bus_if.dec_enable}, 32'd0);
      chk({tag, " rst ex_valid"},    {31'd0, bus_if.ex_valid},   32'd0);
      chk({tag, " rst halted"},      {31'd0, halted},            32'd0);
      chk({tag, " rst dec_instr"},   bus_if.dec_instr,           32'd0);
      chk({tag, " rst outstanding"}, {28'd0, outstanding},       32'd0);
      chk({tag, " rst scoreboard"},  scoreboard,                 32'd0);
   endtask

   initial begin
      vec_t tbl[$];
      bool_dummy: begin end

      // iv instr exr wbv wbrd res | rdy den exv hlt out sb
      // basic ADD x3,x1,x2 then writebacks (stray and x0 ignored)
      tbl.push_back(mk(1'b1, ADD3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,    1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,    1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h8));
      tbl.push_back(mk(1'b0, Z,    1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h8));
      tbl.push_back(mk(1'b0, Z,    1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,    1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,    1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      // capacity: four writes to x1..x4
      tbl.push_back(mk(1'b1, ADDI1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b1, ADDI2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h2));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h2));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h2));
      tbl.push_back(mk(1'b1, ADDI3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h6));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h6));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h6));
      tbl.push_back(mk(1'b1, ADDI4, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 32'hE));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 32'hE));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 32'hE));
      tbl.push_back(mk(1'b1, ADDI7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 32'h1E));
      tbl.push_back(mk(1'b1, SW12,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd4, 32'h1E));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 32'h1E));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 32'h1C));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h18));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h10));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      // EBREAK halt, resume, resume ignored in IDLE
      tbl.push_back(mk(1'b1, EBRK,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b1, ADDI1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0));
      tbl.push_back(mk(1'b1, ADDI1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      // illegal encoding halts too
      tbl.push_back(mk(1'b1, ILL,   1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 32'h0));
      tbl.push_back(mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));

      rst_n           = 1'b0;
      resume          = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.in_instr = ADD3;
      bus_if.ex_ready = 1'b0;
      bus_if.wb_valid = 1'b0;
      bus_if.wb_rd    = 5'd0;
      #12;
      chk_reset("power-on");
      bus_if.in_valid = 1'b0;
      #10;
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) cyc($sformatf("vec%0d", i), tbl[i]);

      // RAW stall on x5
      cyc("raw acc",  mk(1'b1, ADDI5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("raw dec",  mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("raw iss",  mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      cyc("raw st1",  mk(1'b1, ADD6,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h20));
      cyc("raw st2",  mk(1'b1, ADD6,  1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h20));
`ifdef SB_WB_BYPASS_EN
      cyc("raw wb",   mk(1'b1, ADD6,  1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h20));
`else
      cyc("raw wb",   mk(1'b1, ADD6,  1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 32'h20));
      cyc("raw acc2", mk(1'b1, ADD6,  1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
`endif
      cyc("raw dec2", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      chk("raw dec_instr", bus_if.dec_instr, ADD6);
      cyc("raw iss2", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      cyc("raw idle", mk(1'b0, Z,     1'b0, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h40));
      cyc("raw done", mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));

      // ex_ready backpressure for 5 cycles
      cyc("bp acc", mk(1'b1, ADD3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("bp dec", mk(1'b0, Z,    1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      for (int k = 0; k < 5; k++) begin
         cyc($sformatf("bp hold%0d", k), mk(1'b0, Z, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
         chk($sformatf("bp hold%0d dec_instr", k), bus_if.dec_instr, ADD3);
      end
      cyc("bp hs",   mk(1'b0, Z, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      cyc("bp idle", mk(1'b0, Z, 1'b0, 1'b1, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h8));
      chk("bp idle dec_instr", bus_if.dec_instr, ADD3);
      cyc("bp done", mk(1'b0, Z, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));

      // async reset while ISSUE is waiting and two writebacks are pending
      cyc("ar a1", mk(1'b1, ADDI1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("ar d1", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("ar i1", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      cyc("ar a2", mk(1'b1, ADDI2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h2));
      cyc("ar d2", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h2));
      cyc("ar i2", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 32'h2));
      cyc("ar a3", mk(1'b1, ADDI4, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 32'h6));
      cyc("ar d3", mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h6));
      cyc("ar i3", mk(1'b1, ADD3,  1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 32'h6));
      rst_n = 1'b0;
      #1;
      chk_reset("mid-issue");
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      rst_n = 1'b1;
      cyc("post a", mk(1'b1, ADDI1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("post d", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0));
      cyc("post i", mk(1'b0, Z,     1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 32'h0));
      cyc("post w", mk(1'b0, Z,     1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 32'h2));
      cyc("post z", mk(1'b0, Z,     1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/issue_sequencer.md
Name: issue_sequencer

Overview:
- Sequences the decode stage. Accepts instructions from fetch and pulses the decoder enable for exactly one cycle per instruction.
- Waits one cycle for the decoder operand registers to settle, then presents the issue to the execute stage with a valid/ready handshake.
- Keeps a 32-entry register scoreboard, so an instruction that hits a RAW or WAW hazard on a pending writeback is held back.
- Halts after issuing EBREAK until software resumes it.

Parameters:
- MAX_OUTSTANDING, 4: maximum issued instructions whose writeback is still pending (range 1..15).
- CNT_W, 4: width of the outstanding counter; must satisfy 2**CNT_W > MAX_OUTSTANDING.

Ports:
- clk  in  1  clock, all flops rise-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch has an instruction.
- in_instr  in  32  instruction_t from fetch.
- in_ready  out  1  sequencer accepts in_instr this cycle.
- dec_enable  out  1  one-cycle load pulse to the decoder enable.
- dec_instr  out  32  instruction driven to the decoder instr; held stable from accept until issue.
- ex_valid  out  1  decoder op1/op2/op3/rd are valid for execute.
- ex_ready  in  1  execute consumes the issue.
- wb_valid  in  1  writeback completes.
- wb_rd  in  5  register_num_t being written back.
- resume  in  1  single-cycle pulse that leaves HALT.
- halted  out  1  state == HALT.
- outstanding  out  CNT_W  count of pending writebacks.
- scoreboard  out  32  pending-write bitmap; bit 0 is always 0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - in_ready=0, dec_enable=0, ex_valid=0, halted=0.
  - dec_instr=0, outstanding=0, scoreboard=0.
  - Reset mid-operation drops any in-flight instruction; no issue is replayed.
- Field use:
  - rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
  - Classification uses the opcodes package is_r/i/si/s/b/u/j_type functions.
- Source/destination sets by type:
  - r: uses rs1 and rs2, writes rd.
  - i, si: uses rs1, writes rd.
  - s, b: uses rs1 and rs2, writes nothing.
  - u, j: uses no sources, writes rd.
  - EBREAK: uses no sources, writes nothing.
  - Any other encoding is treated as EBREAK (halt-safe).
- Hazard:
  - Set when any used source or a written rd (rd != 0) has its scoreboard bit set.
  - Also set when a written-rd instruction arrives while outstanding == MAX_OUTSTANDING.
- IDLE:
  - in_ready = !hazard(in_instr).
  - On in_valid && in_ready: latch dec_instr, pulse dec_enable for 1 cycle, go to DECODE.
- DECODE:
  - Lasts exactly one cycle, because the decoder registers on enable. Go to ISSUE.
- ISSUE:
  - ex_valid=1, held until ex_ready.
  - On the handshake:
    - if the instruction writes rd != 0, set scoreboard[rd] and increment outstanding.
    - go to HALT if EBREAK or illegal, otherwise go to IDLE.
- HALT:
  - in_ready=0, halted=1.
  - Writebacks continue to drain.
  - resume → IDLE. resume in any other state is ignored.
- Accept-to-issue latency: ex_valid is first asserted 2 cycles after the accept edge. Peak throughput is 1 instruction per 3 cycles.
- Writeback:
  - wb_valid && wb_rd != 0: clear scoreboard[wb_rd] and decrement outstanding.
  - wb_rd == 0 is ignored.
  - A writeback to a register whose bit is clear is ignored; the counter does not change.
- Simultaneous issue-set and wb-clear on the same register: the set wins and outstanding is unchanged (+1 −1).
- Outstanding never exceeds MAX_OUTSTANDING and never goes below 0.

Optional Feature:
- Macro: SB_WB_BYPASS_EN.
- Defined: the hazard check in IDLE uses the scoreboard with this cycle's wb_valid/wb_rd clear already applied, and the outstanding count with this cycle's decrement already applied. A dependent instruction is accepted in the same cycle its source is written back.
- Undefined: the hazard check uses only the registered scoreboard and count. The dependent instruction is accepted one cycle after the writeback.

Test Plan:
- Reset/basic ADD: reset, then ADD x3,x1,x2 (0x002081B3) with ex_ready=1.
  - dec_enable pulses 1 cycle; ex_valid rises 2 cycles after accept.
  - scoreboard=0x00000008, outstanding=1.
- RAW stall: issue ADDI x5,x0,1, then present ADD x6,x5,x5.
  - in_ready=0 until wb_valid with wb_rd=5.
  - With SB_WB_BYPASS_EN, accepted in the wb cycle; without it, accepted one cycle later.
- Capacity: MAX_OUTSTANDING=4, issue 4 writes to x1..x4 with no writeback.
  - A 5th write is held (in_ready=0).
  - A store SW x1→x2 is also held, by the RAW hazard on x1.
- ex_ready backpressure: hold ex_ready=0 for 5 cycles in ISSUE.
  - ex_valid stays 1 and dec_instr stays stable.
  - No scoreboard change until the handshake.
- EBREAK/halt: issue 0x00100073.
  - halted=1 after the handshake; in_ready=0 while halted.
  - A resume pulse returns the block to IDLE; illegal opcode 0xFFFFFFFF behaves the same.
- Async reset mid-ISSUE: drop rst_n while ex_valid=1 and outstanding=2.
  - All outputs reach their reset values without waiting for a clock edge.
  - After release, the next accept behaves normally.
